// File: rtl/mux8_rr_arbiter.sv
// ----------------------------------------------------------------------------
// mux8_rr_arbiter
//
// Round-robin arbiter that shares one 8:1 multiplexer (mux8a1) among eight
// requesters. One requester owns the mux at a time. The arbiter drives the
// mux select code for the owner's data input, and a one-hot grant vector
// tells the requesters which of them currently owns the mux output.
//
// A grant is held until the owner pulses done or drops its request. There is
// always at least one idle cycle between two grants (break-before-make).
//
// Optional feature, selected by macro MUX8_ARB_TIMEOUT_EN:
//   When defined, a hold counter revokes a grant after HOLD_MAX cycles and
//   pulses `expired` in the first cycle after the revoke.
//   When undefined, no counter is built and `expired` is tied low.
//
// Parameters:
//   HOLD_MAX  maximum grant length in cycles when the timeout is built (2..255)
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst      in   1  asynchronous, active-high reset
//   req      in   8  request vector; req[i] owns mux data input i
//   done     in   1  release pulse from the current owner (GRANT only)
//   gnt      out  8  one-hot grant vector, or all zeros
//   sel      out  3  binary mux select of the current or last owner
//   busy     out  1  high while a grant is active
//   expired  out  1  one-cycle pulse after a timeout revoke
// ----------------------------------------------------------------------------
module mux8_rr_arbiter #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       busy,
    output logic       expired
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state_q;
    logic [2:0]  last_q;
    logic [7:0]  gnt_q;
    logic [2:0]  sel_q;
    logic        busy_q;

`ifdef MUX8_ARB_TIMEOUT_EN
    logic [7:0]  hold_q;
    logic        expired_q;
`endif

    // Combinational next-winner search and release decision.
    logic        found_d;
    logic [2:0]  win_d;
    logic [2:0]  idx_d;
    logic        timeout_d;
    logic        release_d;
    logic        expire_d;

    // Search last+1, last+2, ... wrapping modulo 8. The 3-bit add gives the
    // wrap for free; k=8 lands back on last itself, so a lone previous owner
    // is still found.
    always_comb begin
        found_d = 1'b0;
        win_d   = 3'd0;
        idx_d   = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            idx_d = last_q + 3'(k);
            if (!found_d && req[idx_d]) begin
                found_d = 1'b1;
                win_d   = idx_d;
            end
        end
    end

`ifdef MUX8_ARB_TIMEOUT_EN
    // hold_q counts completed GRANT cycles, so it reads HOLD_MAX-1 during the
    // HOLD_MAX-th cycle of the grant; the revoke happens on that cycle's edge.
    assign timeout_d = (hold_q == 8'(HOLD_MAX - 1));
`else
    assign timeout_d = 1'b0;
`endif

    // sel_q holds the owner index throughout GRANT.
    assign release_d = done || !req[sel_q] || timeout_d;

    // Only a revoke caused purely by the timeout is reported; a coincident
    // done or request drop is treated as a normal release.
    assign expire_d  = timeout_d && !done && req[sel_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= 3'd7;
            gnt_q     <= 8'h00;
            sel_q     <= 3'd0;
            busy_q    <= 1'b0;
`ifdef MUX8_ARB_TIMEOUT_EN
            hold_q    <= 8'd0;
            expired_q <= 1'b0;
`endif
        end else begin
`ifdef MUX8_ARB_TIMEOUT_EN
            expired_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        gnt_q   <= 8'b1 << win_d;
                        sel_q   <= win_d;
                        busy_q  <= 1'b1;
                        state_q <= GRANT;
`ifdef MUX8_ARB_TIMEOUT_EN
                        hold_q  <= 8'd0;
`endif
                    end
                end
                GRANT: begin
                    if (release_d) begin
                        // sel_q is deliberately left on the old owner.
                        gnt_q     <= 8'h00;
                        busy_q    <= 1'b0;
                        last_q    <= sel_q;
                        state_q   <= IDLE;
`ifdef MUX8_ARB_TIMEOUT_EN
                        expired_q <= expire_d;
`endif
                    end else begin
`ifdef MUX8_ARB_TIMEOUT_EN
                        hold_q    <= hold_q + 8'd1;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign sel  = sel_q;
    assign busy = busy_q;

`ifdef MUX8_ARB_TIMEOUT_EN
    assign expired = expired_q;
`else
    assign expired = 1'b0;
    logic unused_expire;
    assign unused_expire = expire_d;
`endif

`ifndef SYNTHESIS
    // Structural invariants of the grant outputs.
    a_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_busy   : assert property (@(posedge clk) disable iff (rst) busy == (|gnt));
    a_sel    : assert property (@(posedge clk) disable iff (rst)
                                (gnt == 8'h00) || (gnt == (8'b1 << sel)));
    a_hold   : assert property (@(posedge clk) (HOLD_MAX >= 2) && (HOLD_MAX <= 255));
`endif

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       expired;

    int n_tests;
    int n_fail;

    mux8_rr_arbiter #(.HOLD_MAX(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .expired (expired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit after the next rising edge: outputs are sampled
    // and inputs are changed here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        tick();
        rst  = 1'b0;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        tick();
        tick();
        n_tests++;
        if (gnt !== 8'h00) begin n_fail++; $display("FAIL reset_gnt got %h want 00", gnt); end
        n_tests++;
        if (sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", sel); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_tests++;
        if (expired !== 1'b0) begin n_fail++; $display("FAIL reset_expired got %b want 0", expired); end
        rst = 1'b0;
    endtask

    task automatic test_first_grant();
        req = 8'h01;
        tick();
        n_tests++;
        if (gnt !== 8'h01 || sel !== 3'd0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL first_grant got gnt=%h sel=%0d busy=%b want 01/0/1", gnt, sel, busy);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_tests++;
        if (gnt !== 8'h00 || busy !== 1'b0) begin
            n_fail++; $display("FAIL done_release got gnt=%h busy=%b want 00/0", gnt, busy);
        end
        tick();
        n_tests++;
        if (gnt !== 8'h01 || busy !== 1'b1) begin
            n_fail++; $display("FAIL regrant0 got gnt=%h busy=%b want 01/1", gnt, busy);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_idx;
        do_reset();
        req = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            exp_idx = 3'(i % 8);
            tick();
            n_tests++;
            if (gnt !== (8'b1 << exp_idx) || sel !== exp_idx) begin
                n_fail++; $display("FAIL rr_grant[%0d] got gnt=%h sel=%0d want gnt=%h sel=%0d",
                                   i, gnt, sel, 8'b1 << exp_idx, exp_idx);
            end
            done = 1'b1;
            tick();
            done = 1'b0;
            n_tests++;
            if (gnt !== 8'h00 || sel !== exp_idx) begin
                n_fail++; $display("FAIL rr_gap[%0d] got gnt=%h sel=%0d want gnt=00 sel=%0d",
                                   i, gnt, sel, exp_idx);
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_wrap_priority();
        do_reset();
        req = 8'h40;
        tick();
        n_tests++;
        if (gnt !== 8'h40 || sel !== 3'd6) begin
            n_fail++; $display("FAIL wrap_grant6 got gnt=%h sel=%0d want 40/6", gnt, sel);
        end
        req  = 8'h41;
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        n_tests++;
        if (gnt !== 8'h01 || sel !== 3'd0) begin
            n_fail++; $display("FAIL wrap_next0 got gnt=%h sel=%0d want 01/0", gnt, sel);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        n_tests++;
        if (gnt !== 8'h40 || sel !== 3'd6) begin
            n_fail++; $display("FAIL wrap_then6 got gnt=%h sel=%0d want 40/6", gnt, sel);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_owner_drop();
        // last is 6 here, so the search order is 7,0,1,2,3,...
        req = 8'h18;
        tick();
        n_tests++;
        if (gnt !== 8'h08 || sel !== 3'd3) begin
            n_fail++; $display("FAIL drop_grant3 got gnt=%h sel=%0d want 08/3", gnt, sel);
        end
        req = 8'h10;
        tick();
        n_tests++;
        if (gnt !== 8'h00 || sel !== 3'd3 || busy !== 1'b0) begin
            n_fail++; $display("FAIL drop_release got gnt=%h sel=%0d busy=%b want 00/3/0", gnt, sel, busy);
        end
        tick();
        n_tests++;
        if (gnt !== 8'h10 || sel !== 3'd4) begin
            n_fail++; $display("FAIL drop_next4 got gnt=%h sel=%0d want 10/4", gnt, sel);
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        req = 8'h04;
        tick();
`ifdef MUX8_ARB_TIMEOUT_EN
        for (int c = 1; c <= 4; c++) begin
            n_tests++;
            if (gnt !== 8'h04 || expired !== 1'b0) begin
                n_fail++; $display("FAIL to_hold[%0d] got gnt=%h expired=%b want 04/0", c, gnt, expired);
            end
            if (c < 4) tick();
        end
        tick();
        n_tests++;
        if (gnt !== 8'h00 || expired !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL to_expire got gnt=%h expired=%b busy=%b want 00/1/0", gnt, expired, busy);
        end
        tick();
        n_tests++;
        if (gnt !== 8'h04 || expired !== 1'b0) begin
            n_fail++; $display("FAIL to_regrant got gnt=%h expired=%b want 04/0", gnt, expired);
        end
        // done on the timeout cycle: normal release, no expired pulse.
        tick();
        tick();
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        n_tests++;
        if (gnt !== 8'h00 || expired !== 1'b0) begin
            n_fail++; $display("FAIL to_done_coincide got gnt=%h expired=%b want 00/0", gnt, expired);
        end
`else
        for (int c = 1; c <= 20; c++) begin
            n_tests++;
            if (gnt !== 8'h04 || expired !== 1'b0) begin
                n_fail++; $display("FAIL hold_forever[%0d] got gnt=%h expired=%b want 04/0", c, gnt, expired);
            end
            tick();
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        n_tests++;
        if (gnt !== 8'h00 || expired !== 1'b0) begin
            n_fail++; $display("FAIL hold_release got gnt=%h expired=%b want 00/0", gnt, expired);
        end
`endif
        req = 8'h00;
        tick();
    endtask

    task automatic test_async_reset();
        // Grant and release 5 so last=5; an unreset last would then pick 7.
        req = 8'h20;
        tick();
        req = 8'h00;
        tick();
        req = 8'h20;
        tick();
        n_tests++;
        if (gnt !== 8'h20 || sel !== 3'd5) begin
            n_fail++; $display("FAIL ar_pregrant got gnt=%h sel=%0d want 20/5", gnt, sel);
        end
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (gnt !== 8'h00 || sel !== 3'd0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ar_immediate got gnt=%h sel=%0d busy=%b want 00/0/0", gnt, sel, busy);
        end
        tick();
        rst = 1'b0;
        req = 8'hA0;
        tick();
        n_tests++;
        if (gnt !== 8'h20 || sel !== 3'd5 || busy !== 1'b1) begin
            n_fail++; $display("FAIL ar_first5 got gnt=%h sel=%0d busy=%b want 20/5/1", gnt, sel, busy);
        end
        req = 8'h00;
        tick();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        test_reset();
        test_first_grant();
        test_round_robin();
        test_wrap_priority();
        test_owner_drop();
        test_timeout();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
# mux8_rr_arbiter

- Round-robin arbiter that shares one 8:1 multiplexer (`mux8a1`) among eight requesters.
- Grants one requester at a time and drives the mux select code for that requester's data input.
- Holds the grant until the requester releases it, with an optional hold timeout.
- Sits directly in front of the mux select pins; its one-hot grant vector tells the requesters who owns the mux output.

## Interface
Parameters:
- `HOLD_MAX`, default 16: maximum grant length in cycles when the timeout is compiled in. Range 2–255.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `req` input 8: request vector; `req[i]` is requester i, which owns mux data input i.
- `done` input 1: release pulse from the current owner. Sampled only in GRANT.
- `gnt` output 8: one-hot grant vector, or all zeros.
- `sel` output 3: binary index of the current or last owner. Wire it so that `sel=3'b011` selects input D011.
- `busy` output 1: high while in GRANT.
- `expired` output 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- Two-state FSM: IDLE and GRANT. Reset enters IDLE.
- Internal pointer `last` (3 bits), reset value 7, so requester 0 has first priority after reset.
- IDLE:
  - If `req != 0`, pick the first set bit searching `last+1, last+2, …`, wrapping modulo 8.
  - At the clock edge: `gnt` becomes one-hot on the winner, `sel` takes the winner's index, `busy=1`, go to GRANT.
  - If `req == 0`, stay in IDLE.
  - `done` is ignored in IDLE.
- GRANT: release when any of these is true in a cycle:
  - `done=1`;
  - `req[owner]=0`;
  - timeout reached (see Configuration).
- On release, at the edge:
  - `gnt=0`, `busy=0`, `last=owner`, go to IDLE.
  - `sel` keeps the owner index; it is not cleared.
- Requests from non-owners during GRANT are only recorded by their `req` level. Nothing is queued beyond the level.
- Invariants: `gnt` has at most one bit set; `busy == |gnt`; whenever `gnt != 0`, `sel == index(gnt)`.

## Timing
- Reset values (asynchronous, immediate): `gnt=8'h00`, `sel=3'b000`, `busy=0`, `expired=0`, state IDLE, `last=7`, hold counter 0.
- Grant latency: `req` seen in IDLE at cycle N → `gnt`/`sel`/`busy` valid from cycle N+1.
- Release latency: release condition seen at cycle M → `gnt=0` from cycle M+1.
- Break-before-make: at least one cycle with `gnt=0` between consecutive grants, even with a different requester waiting.
  - Minimum grant-to-grant period is therefore 2 cycles.
  - `sel` changes only on the edge that asserts a new grant.
- Simultaneous events: `done` together with owner `req` drop is a single release. A new request arriving in the release cycle is evaluated in the following IDLE cycle.
- Wrap-around: with `last=7`, the search order is 0,1,…,7. A lone requester is re-granted after each one-cycle gap.
- Reset asserted mid-grant: outputs return to reset values asynchronously, and `last` returns to 7.

## Configuration
- Macro: `MUX8_ARB_TIMEOUT_EN`.
- When defined:
  - An 8-bit hold counter clears on grant and increments each GRANT cycle.
  - When the owner has held `gnt` for `HOLD_MAX` cycles, the grant is released on that edge, with the same rules as `done`.
  - `expired` pulses high for exactly the first cycle with `gnt=0`.
  - If `done` and the timeout coincide, it is a normal release and `expired` stays 0.
- When not defined:
  - No counter is built, and `expired` is tied to 0.
  - A grant lasts until `done` or owner `req` drop, with no limit.

## Test plan
1. **Reset and first grant.**
   - Stimulus: reset, then `req=8'h01`.
   - Required response: `gnt=8'h01`, `sel=0`, `busy=1` one cycle later.
   - Stimulus: `done` pulse.
   - Required response: `gnt=0` next cycle, then re-grant to 0 after the one-cycle gap.
2. **Round-robin fairness.**
   - Stimulus: `req=8'hFF` held; each owner pulses `done` one cycle after its grant.
   - Required response: grant order 0,1,2,…,7,0, with `sel` matching each grant and exactly one `gnt=0` cycle between grants.
3. **Priority after wrap.**
   - Stimulus: owner 6 releases while `req=8'h41`.
   - Required response: next grant goes to 0, not 6; after 0 releases, 6 is granted.
4. **Owner drops request.**
   - Stimulus: grant on 3 with `req=8'h18`, then `req[3]` falls.
   - Required response: `gnt=0` next cycle, then `gnt=8'h10`, `sel=4`.
5. **Timeout** (`MUX8_ARB_TIMEOUT_EN`, `HOLD_MAX=4`).
   - Stimulus: `req=8'h04` held, `done` never asserted.
   - Required response: `gnt=8'h04` for exactly 4 cycles; `expired=1` for one cycle with `gnt=0`; re-grant to 2 afterwards.
   - Without the macro, the grant holds indefinitely and `expired` stays 0.
6. **Asynchronous reset mid-grant.**
   - Stimulus: assert `rst` between clock edges while `gnt=8'h20`.
   - Required response: `gnt=0`, `sel=0`, `busy=0` immediately; after reset, `req=8'hA0` grants 5 first.
